// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: shares the single-port 256x128b data memory between
// port A (processor MEM stage) and port B (debug/preload DMA).
// One operation in flight: IDLE -> ISSUE -> (store) IDLE | (load) RESP -> IDLE.
// Optional feature macro: DM_ARB_RR_EN selects round-robin arbitration;
// when undefined, port A has fixed priority over port B.
module dm_access_arbiter #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // port A
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              done_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  // port B
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              done_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  // memory side
  output logic [1:0]        dm_ctrl_sig,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  // Memory command encodings, matching control.h
  localparam logic [1:0] MEM_NOP = 2'b00;
  localparam logic [1:0] MEM_WLD = 2'b01;
  localparam logic [1:0] MEM_WST = 2'b10;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Request latched at the grant edge
  typedef struct packed {
    logic              we;
    logic              owner;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cap_t;

  state_t state, state_nxt;
  cap_t   cap, cap_nxt;
  logic   win_b;
  logic   any_req;

  assign any_req = req_a | req_b;

`ifdef DM_ARB_RR_EN
  // pri_b=1 means B wins the next simultaneous request
  logic pri_b, pri_b_nxt;

  assign win_b = req_b & (~req_a | pri_b);

  // Hand priority to the port that did not win the latest grant
  always_comb begin
    pri_b_nxt = pri_b;
    if ((state == IDLE) && any_req) begin
      pri_b_nxt = ~win_b;
    end
  end

  // Round-robin pointer, starts favouring A
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pri_b <= 1'b0;
    end else begin
      pri_b <= pri_b_nxt;
    end
  end
`else
  // Fixed priority: A always beats B
  assign win_b = req_b & ~req_a;
`endif

  // State and captured request registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      cap   <= cap_nxt;
    end
  end

  // Next-state, capture and output decode
  always_comb begin
    state_nxt   = state;
    cap_nxt     = cap;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    done_a      = 1'b0;
    done_b      = 1'b0;
    rvalid_a    = 1'b0;
    rvalid_b    = 1'b0;
    rdata_a     = '0;
    rdata_b     = '0;
    dm_ctrl_sig = MEM_NOP;
    dm_addr     = '0;
    dm_wdata    = '0;

    case (state)
      IDLE: begin
        // Grant is suppressed while reset is asserted
        if (any_req && !reset) begin
          gnt_a     = ~win_b;
          gnt_b     = win_b;
          state_nxt = ISSUE;
          if (win_b) begin
            cap_nxt.we    = we_b;
            cap_nxt.owner = OWNER_B;
            cap_nxt.addr  = addr_b;
            cap_nxt.wdata = wdata_b;
          end else begin
            cap_nxt.we    = we_a;
            cap_nxt.owner = OWNER_A;
            cap_nxt.addr  = addr_a;
            cap_nxt.wdata = wdata_a;
          end
        end
      end

      ISSUE: begin
        dm_ctrl_sig = cap.we ? MEM_WST : MEM_WLD;
        dm_addr     = cap.addr;
        dm_wdata    = cap.wdata;
        if (cap.we) begin
          // Write commits at the end of this cycle
          done_a    = (cap.owner == OWNER_A);
          done_b    = (cap.owner == OWNER_B);
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end

      RESP: begin
        // Memory has registered the read word on the ISSUE edge
        if (cap.owner == OWNER_A) begin
          rvalid_a = 1'b1;
          rdata_a  = dm_rdata;
        end else begin
          rvalid_b = 1'b1;
          rdata_b  = dm_rdata;
        end
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed self-checking bench for dm_access_arbiter with a behavioural
// 256x128b registered-read memory attached to the dm_* side.
module tb_dm_access_arbiter;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADDR_W = 32;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] WLD = 2'b01;
  localparam logic [1:0] WST = 2'b10;

  localparam logic [DATA_W-1:0] D = 128'hDEAD0123_456789AB_CDEF0011_2233BEEF;
  localparam logic [DATA_W-1:0] P = 128'h11112222_33334444_55556666_77778888;
  localparam logic [DATA_W-1:0] Q = 128'h99990000_AAAABBBB_CCCCDDDD_EEEEFFFF;

  logic              clk;
  logic              reset;
  logic              req_a, we_a, gnt_a, done_a, rvalid_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a, rdata_a;
  logic              req_b, we_b, gnt_b, done_b, rvalid_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b, rdata_b;
  logic [1:0]        dm_ctrl_sig;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;

  int total;
  int bad;

  logic [DATA_W-1:0] mem [256];

  dm_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .done_a(done_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .done_b(done_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .dm_ctrl_sig(dm_ctrl_sig), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, registered read, 8-bit word index
  always @(posedge clk) begin
    if (dm_ctrl_sig == WST) mem[dm_addr[7:0]] <= dm_wdata;
    else if (dm_ctrl_sig == WLD) dm_rdata <= mem[dm_addr[7:0]];
  end

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DATA_W-1:0] got,
                      input logic [DATA_W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Port A store: grant, ISSUE with done, back in IDLE
  task automatic store_a(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_a = 1'b1; we_a = 1'b1; addr_a = a; wdata_a = d;
    #1;
    chk1("st_gnt_a", gnt_a, 1'b1);
    chk2("st_idle_nop", dm_ctrl_sig, NOP);
    tick();
    req_a = 1'b0;
    #1;
    chk2("st_ctrl_wst", dm_ctrl_sig, WST);
    chkw("st_addr", 128'(dm_addr), 128'(a));
    chkw("st_wdata", dm_wdata, d);
    chk1("st_done_a", done_a, 1'b1);
    chk1("st_gnt_a_low", gnt_a, 1'b0);
    tick();
    #1;
    chk1("st_done_a_low", done_a, 1'b0);
    chk2("st_after_nop", dm_ctrl_sig, NOP);
    chkw("st_after_addr0", 128'(dm_addr), 128'd0);
  endtask

  // Port A load: grant, ISSUE with memwld, RESP with data, back in IDLE
  task automatic load_a(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    req_a = 1'b1; we_a = 1'b0; addr_a = a; wdata_a = '0;
    #1;
    chk1("ld_gnt_a", gnt_a, 1'b1);
    tick();
    req_a = 1'b0;
    #1;
    chk2("ld_ctrl_wld", dm_ctrl_sig, WLD);
    chkw("ld_addr", 128'(dm_addr), 128'(a));
    chk1("ld_rvalid_early", rvalid_a, 1'b0);
    chk1("ld_no_done", done_a, 1'b0);
    tick();
    #1;
    chk1("ld_rvalid_a", rvalid_a, 1'b1);
    chkw("ld_rdata_a", rdata_a, exp);
    chkw("ld_rdata_b_zero", rdata_b, '0);
    chk2("ld_resp_nop", dm_ctrl_sig, NOP);
    tick();
    #1;
    chk1("ld_rvalid_low", rvalid_a, 1'b0);
    chkw("ld_rdata_a_zero", rdata_a, '0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    req_a = 1'b1; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;

    // Reset state, with a request pending that must not be granted
    tick();
    tick();
    chk1("rst_gnt_a", gnt_a, 1'b0);
    chk2("rst_ctrl", dm_ctrl_sig, NOP);
    chkw("rst_addr", 128'(dm_addr), 128'd0);
    chkw("rst_wdata", dm_wdata, '0);
    chk1("rst_rvalid_a", rvalid_a, 1'b0);
    chkw("rst_rdata_a", rdata_a, '0);
    req_a = 1'b0;
    reset = 1'b0;
    tick();

    // 1: store A to 0x05
    store_a(32'h05, D);
    // 2: load A from 0x05
    load_a(32'h05, D);
    // 4: 0x105 aliases word 0x05
    load_a(32'h105, D);

    // 5: reset in ISSUE of a store aborts it
    store_a(32'h07, P);
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h07; wdata_a = Q;
    #1;
    chk1("abort_gnt_a", gnt_a, 1'b1);
    tick();
    req_a = 1'b0;
    #1;
    chk2("abort_ctrl_wst", dm_ctrl_sig, WST);
    reset = 1'b1;
    #1;
    chk2("abort_ctrl_nop", dm_ctrl_sig, NOP);
    chk1("abort_no_done", done_a, 1'b0);
    chkw("abort_addr0", 128'(dm_addr), 128'd0);
    tick();
    reset = 1'b0;
    #1;
    chk2("abort_idle_nop", dm_ctrl_sig, NOP);
    chk1("abort_idle_gnt", gnt_a, 1'b0);
    chk1("abort_idle_done", done_a, 1'b0);
    load_a(32'h07, P);

    // 6: B requests during A's RESP, granted only in the following IDLE
    req_a = 1'b1; we_a = 1'b0; addr_a = 32'h05;
    #1;
    chk1("ov_gnt_a", gnt_a, 1'b1);
    tick();
    req_a = 1'b0;
    #1;
    chk2("ov_ctrl_wld", dm_ctrl_sig, WLD);
    tick();
    req_b = 1'b1; we_b = 1'b0; addr_b = 32'h105;
    #1;
    chk1("ov_rvalid_a", rvalid_a, 1'b1);
    chk1("ov_gnt_b_wait", gnt_b, 1'b0);
    tick();
    #1;
    chk1("ov_gnt_b", gnt_b, 1'b1);
    chk1("ov_rvalid_a_low", rvalid_a, 1'b0);
    tick();
    req_b = 1'b0;
    #1;
    chk2("ov_ctrl_wld_b", dm_ctrl_sig, WLD);
    chkw("ov_addr_b", 128'(dm_addr), 128'h105);
    tick();
    #1;
    chk1("ov_rvalid_b", rvalid_b, 1'b1);
    chkw("ov_rdata_b", rdata_b, D);
    chk1("ov_rvalid_a_off", rvalid_a, 1'b0);
    chkw("ov_rdata_a_zero", rdata_a, '0);
    tick();

    // 3: both ports hold store requests for four grants
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h10; wdata_a = P;
    req_b = 1'b1; we_b = 1'b1; addr_b = 32'h20; wdata_b = Q;
    for (int i = 0; i < 4; i++) begin
      logic exp_b;
`ifdef DM_ARB_RR_EN
      exp_b = 1'(i % 2);
`else
      exp_b = 1'b0;
`endif
      #1;
      chk1("arb_gnt_a", gnt_a, ~exp_b);
      chk1("arb_gnt_b", gnt_b, exp_b);
      tick();
      #1;
      chk1("arb_done_a", done_a, ~exp_b);
      chk1("arb_done_b", done_b, exp_b);
      chkw("arb_wdata", dm_wdata, exp_b ? Q : P);
      tick();
    end
    req_a = 1'b0;
    req_b = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
